// File: rtl/dma_chan_arbiter.sv
// dma_chan_arbiter: shares a single DMA engine between NR_CHAN requesting channels.
// Channels are served round-robin. The winner's descriptor is latched and driven
// to the engine, and the engine's status word is monitored until completion or
// timeout. A one-cycle done/error pulse is then returned to the granted channel.
// Build option: define DMA_ARB_PRIO_EN to give channel 0 fixed top priority.
module dma_chan_arbiter #(
  parameter int NR_CHAN        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NR_CHAN-1:0]              req_i,
  input  logic [NR_CHAN*DATA_WIDTH-1:0]   len_i,
  input  logic [NR_CHAN*2*DATA_WIDTH-1:0] src_i,
  input  logic [NR_CHAN*2*DATA_WIDTH-1:0] dst_i,
  output logic [NR_CHAN-1:0]              gnt_o,
  output logic [NR_CHAN-1:0]              chan_done_o,
  output logic [NR_CHAN-1:0]              chan_err_o,
  output logic                            busy_o,
  output logic [DATA_WIDTH-1:0]           dma_start_o,
  output logic [DATA_WIDTH-1:0]           dma_length_o,
  output logic [DATA_WIDTH-1:0]           dma_src_lsb_o,
  output logic [DATA_WIDTH-1:0]           dma_src_msb_o,
  output logic [DATA_WIDTH-1:0]           dma_dst_lsb_o,
  output logic [DATA_WIDTH-1:0]           dma_dst_msb_o,
  output logic [DATA_WIDTH-1:0]           dma_done_o,
  input  logic [DATA_WIDTH-1:0]           dma_valid_i
);

  localparam int IDX_W = $clog2(NR_CHAN);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE_ACK, RELEASE} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, gidx_q, pick_idx, ptr_next;
  logic                  pick_vld;
  logic                  issue_cnt_q;
  logic [15:0]           cnt_q;
  logic                  err_q;
  logic [NR_CHAN-1:0]    gnt_q;
  logic [DATA_WIDTH-1:0] len_q, src_lsb_q, src_msb_q, dst_lsb_q, dst_msb_q;
  logic                  done_seen, timeout_hit;
  logic                  unused_valid_bits;

  // Only the store (bit2) and done (bit3) flags influence the controller.
  assign unused_valid_bits = ^{dma_valid_i[DATA_WIDTH-1:4], dma_valid_i[1:0]};

  assign done_seen   = dma_valid_i[3];
  assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign ptr_next    = (gidx_q == IDX_W'(NR_CHAN - 1)) ? '0 : gidx_q + 1'b1;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    wrap_idx = IDX_W'(v % NR_CHAN);
  endfunction

  // Round-robin pick: first requesting channel at or after ptr, with wrap.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < NR_CHAN; i++) begin
      if (!pick_vld && req_i[wrap_idx(int'(ptr_q) + i)]) begin
        pick_vld = 1'b1;
        pick_idx = wrap_idx(int'(ptr_q) + i);
      end
    end
`ifdef DMA_ARB_PRIO_EN
    if (req_i[0]) begin
      pick_vld = 1'b1;
      pick_idx = '0;
    end
`endif
  end

  // State register; async reset aborts any transfer without a done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and engine/channel strobes decoded from the current state.
  always_comb begin
    state_d      = state_q;
    busy_o       = 1'b1;
    dma_start_o  = '0;
    dma_done_o   = '0;
    chan_done_o  = '0;
    chan_err_o   = '0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (pick_vld) state_d = ISSUE;
      end
      ISSUE: begin
        dma_start_o = DATA_WIDTH'(1);
        if (issue_cnt_q) state_d = WAIT;
      end
      WAIT: begin
        if (done_seen || timeout_hit) state_d = DONE_ACK;
      end
      DONE_ACK: begin
        dma_done_o  = DATA_WIDTH'(1);
        chan_done_o = gnt_q;
        chan_err_o  = err_q ? gnt_q : '0;
        state_d     = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, descriptor latch, wait counter, error flag and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      gidx_q      <= '0;
      gnt_q       <= '0;
      issue_cnt_q <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      len_q       <= '0;
      src_lsb_q   <= '0;
      src_msb_q   <= '0;
      dst_lsb_q   <= '0;
      dst_msb_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gidx_q      <= pick_idx;
            gnt_q       <= NR_CHAN'(1) << pick_idx;
            issue_cnt_q <= 1'b0;
            err_q       <= 1'b0;
            len_q       <= len_i[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            src_lsb_q   <= src_i[int'(pick_idx)*2*DATA_WIDTH +: DATA_WIDTH];
            src_msb_q   <= src_i[int'(pick_idx)*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
            dst_lsb_q   <= dst_i[int'(pick_idx)*2*DATA_WIDTH +: DATA_WIDTH];
            dst_msb_q   <= dst_i[int'(pick_idx)*2*DATA_WIDTH + DATA_WIDTH +: DATA_WIDTH];
          end
        end
        ISSUE: issue_cnt_q <= 1'b1;
        WAIT: begin
          cnt_q <= cnt_q + 16'd1;
          // A done report takes precedence over a coincident timeout.
          if (done_seen)        err_q <= ~dma_valid_i[2];
          else if (timeout_hit) err_q <= 1'b1;
        end
        DONE_ACK: gnt_q <= '0;
        RELEASE: begin
          cnt_q <= '0;
`ifdef DMA_ARB_PRIO_EN
          if (gidx_q != '0) ptr_q <= ptr_next;
`else
          ptr_q <= ptr_next;
`endif
        end
        default: ;
      endcase
    end
  end

  assign gnt_o         = gnt_q;
  assign dma_length_o  = len_q;
  assign dma_src_lsb_o = src_lsb_q;
  assign dma_src_msb_o = src_msb_q;
  assign dma_dst_lsb_o = dst_lsb_q;
  assign dma_dst_msb_o = dst_msb_q;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// Testbench for dma_chan_arbiter: directed and randomized transfers checked
// against a behavioural model of the arbitration order and transfer outcome.
module tb_dma_chan_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TO  = 16;

  logic                  clk;
  logic                  rst_ni;
  logic [NCH-1:0]        req_i;
  logic [NCH*DW-1:0]     len_i;
  logic [NCH*2*DW-1:0]   src_i;
  logic [NCH*2*DW-1:0]   dst_i;
  logic [NCH-1:0]        gnt_o;
  logic [NCH-1:0]        chan_done_o;
  logic [NCH-1:0]        chan_err_o;
  logic                  busy_o;
  logic [DW-1:0]         dma_start_o;
  logic [DW-1:0]         dma_length_o;
  logic [DW-1:0]         dma_src_lsb_o;
  logic [DW-1:0]         dma_src_msb_o;
  logic [DW-1:0]         dma_dst_lsb_o;
  logic [DW-1:0]         dma_dst_msb_o;
  logic [DW-1:0]         dma_done_o;
  logic [DW-1:0]         dma_valid_i;

  int tests = 0;
  int fails = 0;
  int mptr  = 0;

  dma_chan_arbiter #(
    .NR_CHAN        (NCH),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req_i),
    .len_i         (len_i),
    .src_i         (src_i),
    .dst_i         (dst_i),
    .gnt_o         (gnt_o),
    .chan_done_o   (chan_done_o),
    .chan_err_o    (chan_err_o),
    .busy_o        (busy_o),
    .dma_start_o   (dma_start_o),
    .dma_length_o  (dma_length_o),
    .dma_src_lsb_o (dma_src_lsb_o),
    .dma_src_msb_o (dma_src_msb_o),
    .dma_dst_lsb_o (dma_dst_lsb_o),
    .dma_dst_msb_o (dma_dst_msb_o),
    .dma_done_o    (dma_done_o),
    .dma_valid_i   (dma_valid_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] onehot(input int w);
    logic [DW-1:0] r;
    r = '0;
    r[w] = 1'b1;
    return r;
  endfunction

  // Reference arbitration: scan from the pointer upward with wrap.
  function automatic int exp_winner(input logic [NCH-1:0] r, input int p);
`ifdef DMA_ARB_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int i = 0; i < NCH; i++)
      if (r[(p + i) % NCH]) return (p + i) % NCH;
    return -1;
  endfunction

  task automatic rand_desc();
    for (int c = 0; c < NCH; c++) begin
      len_i[c*DW +: DW]        = $urandom;
      src_i[c*2*DW +: DW]      = $urandom;
      src_i[c*2*DW + DW +: DW] = $urandom;
      dst_i[c*2*DW +: DW]      = $urandom;
      dst_i[c*2*DW + DW +: DW] = $urandom;
    end
  endtask

  // One full transfer from IDLE back to IDLE. lat < 0: engine never reports done.
  task automatic run_txn(input logic [NCH-1:0] req, input int lat,
                         input logic [DW-1:0] vld, input bit drop);
    int w;
    bit exp_err;
    logic [DW-1:0] e_len, e_sl, e_sm, e_dl, e_dm;
    check("idle_busy", 32'(busy_o), 0);
    req_i   = req;
    w       = exp_winner(req, mptr);
    e_len   = len_i[w*DW +: DW];
    e_sl    = src_i[w*2*DW +: DW];
    e_sm    = src_i[w*2*DW + DW +: DW];
    e_dl    = dst_i[w*2*DW +: DW];
    e_dm    = dst_i[w*2*DW + DW +: DW];
    exp_err = (lat < 0) ? 1'b1 : !vld[2];
    @(posedge clk); #1;
    check("gnt", 32'(gnt_o), onehot(w));
    check("busy", 32'(busy_o), 1);
    check("start_c1", dma_start_o, 1);
    check("len", dma_length_o, e_len);
    check("src_lsb", dma_src_lsb_o, e_sl);
    check("src_msb", dma_src_msb_o, e_sm);
    check("dst_lsb", dma_dst_lsb_o, e_dl);
    check("dst_msb", dma_dst_msb_o, e_dm);
    rand_desc();
    if (drop) req_i = '0;
    @(posedge clk); #1;
    check("start_c2", dma_start_o, 1);
    @(posedge clk); #1;
    check("start_off", dma_start_o, 0);
    check("gnt_wait", 32'(gnt_o), onehot(w));
    for (int k = 0; k < TO; k++) begin
      if (k == lat) dma_valid_i = vld;
      else          dma_valid_i = $urandom & ~32'h8;
      @(posedge clk); #1;
      if (k == lat || k == TO - 1) break;
      check("no_done", 32'(chan_done_o), 0);
    end
    dma_valid_i = '0;
    check("dma_done", dma_done_o, 1);
    check("chan_done", 32'(chan_done_o), onehot(w));
    check("chan_err", 32'(chan_err_o), exp_err ? onehot(w) : 32'd0);
    check("len_hold", dma_length_o, e_len);
    check("dst_hold", dma_dst_msb_o, e_dm);
    @(posedge clk); #1;
    check("rel_gnt", 32'(gnt_o), 0);
    check("rel_done", 32'(chan_done_o), 0);
    check("rel_dma_done", dma_done_o, 0);
`ifdef DMA_ARB_PRIO_EN
    if (w != 0) mptr = (w + 1) % NCH;
`else
    mptr = (w + 1) % NCH;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    int lat;
    rst_ni      = 1'b0;
    req_i       = '0;
    len_i       = '0;
    src_i       = '0;
    dst_i       = '0;
    dma_valid_i = '0;
    #1;
    check("rst_gnt", 32'(gnt_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_start", dma_start_o, 0);
    check("rst_len", dma_length_o, 0);
    check("rst_done", dma_done_o, 0);
    #16 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Fairness: all channels requesting, expect 0,1,2,3,0.
    for (int n = 0; n < 5; n++) begin
      rand_desc();
      run_txn(4'b1111, $urandom_range(0, 6), 32'hE, 1'b0);
    end

    // Single request with length 3, successful store.
    rand_desc();
    len_i[1*DW +: DW] = 32'd3;
    run_txn(4'b0010, 2, 32'hE, 1'b0);

    // Length 0, request dropped after grant.
    rand_desc();
    len_i[2*DW +: DW] = 32'd0;
    run_txn(4'b0100, 1, 32'hE, 1'b1);

    // PMP denial: done without store bit.
    rand_desc();
    run_txn(4'b1000, 3, 32'h8, 1'b0);

    // Timeout, then done and timeout coinciding (done wins).
    rand_desc();
    run_txn(4'b0101, -1, 32'h0, 1'b0);
    rand_desc();
    run_txn(4'b1111, TO - 1, 32'hE, 1'b0);

    // Randomized transfers.
    for (int n = 0; n < 20; n++) begin
      rand_desc();
      v   = $urandom | 32'h8;
      lat = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TO - 1));
      run_txn(4'($urandom_range(1, 15)), lat, v, 1'($urandom_range(0, 1)));
    end

    // Reset asserted while waiting on the engine.
    rand_desc();
    req_i = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_i = '0;
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_done", 32'(chan_done_o), 0);
    check("mid_rst_len", dma_length_o, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_ni = 1'b1;
    @(posedge clk); #1;
    mptr = 0;
    rand_desc();
    run_txn(4'b1111, 2, 32'hE, 1'b0);

`ifdef DMA_ARB_PRIO_EN
    for (int n = 0; n < 3; n++) begin
      rand_desc();
      run_txn(4'b1111, 1, 32'hE, 1'b0);
    end
    for (int n = 0; n < 3; n++) begin
      rand_desc();
      run_txn(4'b1110, 1, 32'hE, 1'b0);
    end
`endif

    req_i = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
